timebase_update_ctrl: RTL and testbench
=======================================

// Module: timebase_update_ctrl
// PURPOSE
//  Configuration sequencer for the PWM timebase counter. Holds the live period/prescale values that
//  drive the timebase, and stages new values written over APB. Commits staged values either at once
//  or exactly on the timebase wrap boundary, so that a partial period never runs with mixed settings.
//  Sits between the APB register file and the timebase counter.
// PARAMETERS
//  APB_DWIDTH    8  width of the period, prescale and cfg data paths
//  RST_PERIOD    0  value of period_reg after reset
//  RST_PRESCALE  0  value of prescale_reg after reset
// PORTS
//  PCLK          in   1           clock; the single clock of this block
//  PRESET        in   1           reset, synchronous, active-high
//  wr_period     in   1           write cfg_wdata into the staged period
//  wr_prescale   in   1           write cfg_wdata into the staged prescale
//  cfg_wdata     in   APB_DWIDTH  write data
//  commit_req    in   1           one-cycle pulse: request transfer of staged values to the live values
//  sync_mode     in   1           sampled with commit_req: 1 = commit at boundary, 0 = commit immediately
//  abort         in   1           cancel a pending commit
//  period_cnt    in   APB_DWIDTH  current count from the timebase
//  sync_pulse    in   1           prescale-terminal indication from the timebase
//  period_reg    out  APB_DWIDTH  live period value driving the timebase (registered)
//  prescale_reg  out  APB_DWIDTH  live prescale value driving the timebase (registered)
//  pending       out  1           high while the FSM is in PENDING
//  update_done   out  1           one-cycle pulse, high in the first cycle new live values are visible
//  wr_err        out  1           one-cycle pulse: a write was dropped during PENDING
//  commit_cnt    out  8           number of completed commits; wraps 255->0
// BEHAVIOUR
//  Reset (PRESET=1 at a PCLK edge): all reset values are sampled synchronously.
//   - period_reg and the staged period = RST_PERIOD
//   - prescale_reg and the staged prescale = RST_PRESCALE
//   - state = IDLE; pending, update_done, wr_err and commit_cnt = 0
//   - Reset while PENDING discards the pending commit.
//  Boundary:
//   - boundary = sync_pulse && (period_cnt >= period_reg), evaluated on the current live values.
//   - This is the same cycle in which the timebase wraps period_cnt to 0.
//  Staging writes:
//   - In IDLE, wr_period / wr_prescale load staging at the edge. Both may be asserted together.
//   - In PENDING, writes are ignored, staging stays frozen, and wr_err pulses for 1 cycle.
//  FSM IDLE:
//   - commit_req && abort: abort wins; no effect.
//   - commit_req && !sync_mode: load live regs from staging at this edge.
//     - A same-cycle write is forwarded: the written value is committed.
//     - update_done = 1 next cycle; stay in IDLE.
//     - Latency: new values are visible 1 cycle after the commit_req cycle.
//   - commit_req && sync_mode: go to PENDING. A same-cycle write lands in staging first.
//  FSM PENDING:
//   - abort: return to IDLE; live regs unchanged; no update_done.
//   - boundary (and no abort): load live regs at this edge, pulse update_done, return to IDLE.
//     - The timebase's first post-wrap count therefore uses the new values.
//   - abort and boundary in the same cycle: abort wins.
//   - commit_req while PENDING: ignored; no queueing.
//  commit_cnt increments by 1 on every live-register load, modulo 256.
//  Commits in back-to-back cycles are legal; each produces its own update_done.
//  Zero values are legal, e.g. prescale 0 means a boundary can occur in consecutive cycles.
// TESTING
//  1 Reset with RST_PERIOD=8'h10, RST_PRESCALE=8'h03 -> period_reg=10, prescale_reg=03;
//    pending=0, update_done=0, commit_cnt=0.
//  2 Immediate commit: write period=8'h20, then commit_req with sync_mode=0
//    -> period_reg=20 on the next cycle; update_done pulses for 1 cycle; commit_cnt=1.
//  3 Boundary commit: live regs 05/02, stage 09/01, commit_req with sync_mode=1 -> pending=1;
//    live regs hold 05/02 until the cycle period_cnt=5 && sync_pulse=1;
//    the next cycle shows 09/01, update_done=1, pending=0.
//  4 Write during PENDING (period=8'h33) -> wr_err pulses; the later boundary commits the pre-PENDING
//    staged value, not 33.
//  5 Abort and boundary in the same cycle -> IDLE; live regs unchanged; no update_done; commit_cnt unchanged.
//  6 PRESET asserted mid-PENDING -> IDLE, live and staged regs at reset values; no commit on the next boundary.

Source files
------------

// File: rtl/timebase_update_ctrl.sv
// Staged period/prescale update sequencer for the PWM timebase.
// Commits immediately or on the timebase wrap boundary.
module timebase_update_ctrl #(
  parameter int APB_DWIDTH = 8,
  parameter logic [APB_DWIDTH-1:0] RST_PERIOD   = '0,
  parameter logic [APB_DWIDTH-1:0] RST_PRESCALE = '0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  wr_period,
  input  logic                  wr_prescale,
  input  logic [APB_DWIDTH-1:0] cfg_wdata,
  input  logic                  commit_req,
  input  logic                  sync_mode,
  input  logic                  abort,
  input  logic [APB_DWIDTH-1:0] period_cnt,
  input  logic                  sync_pulse,
  output logic [APB_DWIDTH-1:0] period_reg,
  output logic [APB_DWIDTH-1:0] prescale_reg,
  output logic                  pending,
  output logic                  update_done,
  output logic                  wr_err,
  output logic [7:0]            commit_cnt
);

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  state_t state_q, state_d;

  logic [APB_DWIDTH-1:0] stg_per_q, stg_per_d;
  logic [APB_DWIDTH-1:0] stg_pre_q, stg_pre_d;
  logic                  load;
  logic                  boundary;
  logic                  wr_any;

  assign boundary = sync_pulse && (period_cnt >= period_reg);
  assign wr_any   = wr_period || wr_prescale;
  assign pending  = (state_q == PENDING);

  // Live regs load from the next staging value, so a
  // same-cycle write in IDLE is forwarded into the commit.
  always_comb begin
    state_d   = state_q;
    stg_per_d = stg_per_q;
    stg_pre_d = stg_pre_q;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_period)   stg_per_d = cfg_wdata;
        if (wr_prescale) stg_pre_d = cfg_wdata;
        if (commit_req && !abort) begin
          if (sync_mode) state_d = PENDING;
          else           load    = 1'b1;
        end
      end
      PENDING: begin
        if (abort) begin
          state_d = IDLE;
        end else if (boundary) begin
          load    = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= IDLE;
      stg_per_q    <= RST_PERIOD;
      stg_pre_q    <= RST_PRESCALE;
      period_reg   <= RST_PERIOD;
      prescale_reg <= RST_PRESCALE;
      update_done  <= 1'b0;
      wr_err       <= 1'b0;
      commit_cnt   <= 8'd0;
    end else begin
      state_q     <= state_d;
      stg_per_q   <= stg_per_d;
      stg_pre_q   <= stg_pre_d;
      update_done <= load;
      wr_err      <= pending && wr_any;
      if (load) begin
        period_reg   <= stg_per_d;
        prescale_reg <= stg_pre_d;
        commit_cnt   <= commit_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_timebase_update_ctrl.sv
// Scoreboard bench for timebase_update_ctrl.
// Expected commits queued at stimulus, checked on update_done.
module tb_timebase_update_ctrl;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       wr_period, wr_prescale;
  logic [7:0] cfg_wdata;
  logic       commit_req, sync_mode, abort;
  logic [7:0] period_cnt;
  logic       sync_pulse;
  logic [7:0] period_reg, prescale_reg;
  logic       pending, update_done, wr_err;
  logic [7:0] commit_cnt;

  typedef struct packed {
    logic [7:0] per;
    logic [7:0] pre;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 PCLK = ~PCLK;

  timebase_update_ctrl #(
    .APB_DWIDTH  (8),
    .RST_PERIOD  (8'h10),
    .RST_PRESCALE(8'h03)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .wr_period   (wr_period),
    .wr_prescale (wr_prescale),
    .cfg_wdata   (cfg_wdata),
    .commit_req  (commit_req),
    .sync_mode   (sync_mode),
    .abort       (abort),
    .period_cnt  (period_cnt),
    .sync_pulse  (sync_pulse),
    .period_reg  (period_reg),
    .prescale_reg(prescale_reg),
    .pending     (pending),
    .update_done (update_done),
    .wr_err      (wr_err),
    .commit_cnt  (commit_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge PCLK) begin
    if (!PRESET && update_done) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_update", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_period", period_reg, e.per);
        chk("sb_prescale", prescale_reg, e.pre);
        chk("sb_cnt", commit_cnt, e.cnt);
      end
    end
  end

  task automatic idle_in();
    PRESET = 0; wr_period = 0; wr_prescale = 0;
    cfg_wdata = 0; commit_req = 0; sync_mode = 0;
    abort = 0; period_cnt = 0; sync_pulse = 0;
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
    idle_in();
  endtask

  task automatic push(input logic [7:0] p,
                      input logic [7:0] s,
                      input logic [7:0] c);
    exp_t e;
    e.per = p; e.pre = s; e.cnt = c;
    sb_q.push_back(e);
  endtask

  initial begin
    idle_in();
    PRESET = 1;
    tick();
    PRESET = 1;
    tick();
    // 1 reset values
    chk("rst_period", period_reg, 8'h10);
    chk("rst_prescale", prescale_reg, 8'h03);
    chk("rst_pending", pending, 0);
    chk("rst_upd", update_done, 0);
    chk("rst_cnt", commit_cnt, 0);
    chk("rst_wrerr", wr_err, 0);

    // 2 immediate commit
    wr_period = 1; cfg_wdata = 8'h20;
    tick();
    chk("stage_no_live", period_reg, 8'h10);
    commit_req = 1; sync_mode = 0;
    push(8'h20, 8'h03, 8'd1);
    tick();
    chk("imm_period", period_reg, 8'h20);
    chk("imm_upd", update_done, 1);
    chk("imm_pending", pending, 0);
    tick();
    chk("imm_upd_once", update_done, 0);
    chk("imm_cnt", commit_cnt, 1);

    // forwarded write into immediate commit
    wr_prescale = 1; cfg_wdata = 8'h02;
    tick();
    wr_period = 1; cfg_wdata = 8'h05;
    commit_req = 1;
    push(8'h05, 8'h02, 8'd2);
    tick();
    chk("fwd_period", period_reg, 8'h05);
    chk("fwd_prescale", prescale_reg, 8'h02);

    // commit_req with abort in IDLE: no effect
    commit_req = 1; abort = 1;
    tick();
    chk("idle_abort_upd", update_done, 0);
    chk("idle_abort_pend", pending, 0);

    // 3 boundary commit 05/02 -> 09/01
    wr_period = 1; cfg_wdata = 8'h09;
    tick();
    wr_prescale = 1; cfg_wdata = 8'h01;
    commit_req = 1; sync_mode = 1;
    push(8'h09, 8'h01, 8'd3);
    tick();
    chk("sync_pending", pending, 1);
    chk("sync_hold", period_reg, 8'h05);
    period_cnt = 8'h03; sync_pulse = 1;
    tick();
    chk("below_hold", period_reg, 8'h05);
    period_cnt = 8'h05; sync_pulse = 0;
    tick();
    chk("nopulse_pend", pending, 1);
    period_cnt = 8'h05; sync_pulse = 1;
    tick();
    chk("bnd_period", period_reg, 8'h09);
    chk("bnd_prescale", prescale_reg, 8'h01);
    chk("bnd_upd", update_done, 1);
    chk("bnd_pending", pending, 0);

    // 4 write during PENDING is dropped
    wr_period = 1; cfg_wdata = 8'h0A;
    tick();
    commit_req = 1; sync_mode = 1;
    push(8'h0A, 8'h01, 8'd4);
    tick();
    wr_period = 1; cfg_wdata = 8'h33;
    tick();
    chk("wrerr_pulse", wr_err, 1);
    commit_req = 1; sync_mode = 0;
    tick();
    chk("wrerr_once", wr_err, 0);
    chk("pend_commitreq", pending, 1);
    chk("pend_no_upd", update_done, 0);
    period_cnt = 8'h0C; sync_pulse = 1;
    tick();
    chk("drop_period", period_reg, 8'h0A);

    // 5 abort beats boundary
    wr_period = 1; cfg_wdata = 8'h07;
    tick();
    commit_req = 1; sync_mode = 1;
    tick();
    abort = 1; period_cnt = 8'h0A; sync_pulse = 1;
    tick();
    chk("abort_pend", pending, 0);
    chk("abort_upd", update_done, 0);
    chk("abort_period", period_reg, 8'h0A);
    chk("abort_cnt", commit_cnt, 4);

    // back-to-back immediate commits (staged 07/01)
    commit_req = 1;
    push(8'h07, 8'h01, 8'd5);
    tick();
    chk("b2b_upd1", update_done, 1);
    commit_req = 1;
    push(8'h07, 8'h01, 8'd6);
    tick();
    chk("b2b_upd2", update_done, 1);
    chk("b2b_cnt", commit_cnt, 6);

    // 6 reset mid-PENDING
    wr_period = 1; cfg_wdata = 8'h44;
    commit_req = 1; sync_mode = 1;
    tick();
    chk("pre_rst_pend", pending, 1);
    PRESET = 1;
    tick();
    chk("mid_rst_pend", pending, 0);
    chk("mid_rst_period", period_reg, 8'h10);
    chk("mid_rst_prescale", prescale_reg, 8'h03);
    chk("mid_rst_cnt", commit_cnt, 0);
    period_cnt = 8'h20; sync_pulse = 1;
    tick();
    chk("post_rst_noupd", update_done, 0);
    chk("post_rst_period", period_reg, 8'h10);
    commit_req = 1;
    push(8'h10, 8'h03, 8'd1);
    tick();
    chk("rst_stage_period", period_reg, 8'h10);
    chk("rst_stage_prescale", prescale_reg, 8'h03);
    tick();
    tick();

    chk("sb_left", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
